// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the two-digit BCD 7-segment display path.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
package bcd_disp_pkg;

    typedef enum logic {
        DIG_ONES = 1'b0,
        DIG_TENS = 1'b1
    } digit_e;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam logic [1:0] AN_OFF  = 2'b00;
    localparam logic [1:0] AN_ONES = 2'b01;
    localparam logic [1:0] AN_TENS = 2'b10;

    function automatic logic is_bcd(input logic [3:0] nibble);
        return nibble <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd2_seg_mux_driver.sv
// Two-digit BCD latch and time-multiplexed 7-segment driver with registered outputs.
// Optional macro LEADING_ZERO_BLANK_EN blanks the tens slot while the latched tens digit is 0.
module bcd2_seg_mux_driver
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_ones,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       bcd_err
);

    localparam int                CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    digit_e           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       tens_q, ones_q;
    logic [3:0]       mux_digit;
    logic [6:0]       dec_seg;
    logic             blank;
    logic [6:0]       seg_next;
    logic [1:0]       an_next;
    logic             err_next;

    // NOTE: every sequential block uses non-blocking assignments so all registers
    // sample the same pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= DIG_ONES;
            cnt    <= '0;
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (load) begin
                tens_q <= bcd_tens;
                ones_q <= bcd_ones;
            end
        end
    end

    // NOTE: each always_comb assigns defaults first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_next   = cnt + 1'b1;
        state_next = state;
        if (cnt == CNT_MAX) begin
            cnt_next   = '0;
            state_next = (state == DIG_ONES) ? DIG_TENS : DIG_ONES;
        end
    end

    assign mux_digit = (state == DIG_TENS) ? tens_q : ones_q;

    bcd_to_seg7 u_dec (
        .digit (mux_digit),
        .seg   (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign blank = (state == DIG_TENS) && (tens_q == 4'd0);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        seg_next = dec_seg;
        an_next  = (state == DIG_TENS) ? AN_TENS : AN_ONES;
        if (blank) begin
            seg_next = SEG_OFF;
            an_next  = AN_OFF;
        end
        err_next = !is_bcd(tens_q) || !is_bcd(ones_q);
    end

    // Output stage lags state and latched digits by exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg     <= SEG_OFF;
            an      <= AN_OFF;
            bcd_err <= 1'b0;
        end else begin
            seg     <= seg_next;
            an      <= an_next;
            bcd_err <= err_next;
        end
    end

endmodule
